// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-style in-service/priority block.
// Holds the handshake state enum, EOI command codes and the priority rotator.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam logic [1:0] EOI_NS  = 2'b00;
    localparam logic [1:0] EOI_SP  = 2'b01;
    localparam logic [1:0] EOI_RNS = 2'b10;
    localparam logic [1:0] EOI_RSP = 2'b11;

    // Bit 0 of the result is the highest-priority level, (lowest+1) mod n.
    function automatic logic [63:0] rotate_prio(
        input logic [63:0] v,
        input int unsigned lowest,
        input int unsigned n
    );
        logic [63:0] r;
        logic [5:0]  k;
        r = '0;
        for (int unsigned i = 0; i < n; i++) begin
            k = 6'((i + lowest + 1) % n);
            r[6'(i)] = v[k];
        end
        return r;
    endfunction

endpackage

// File: rtl/pic_isr_ctrl_if.sv
// CPU-side acknowledge handshake of the interrupt controller.
// The controller drives the request and vector; the CPU drives INTA.
interface pic_isr_ctrl_if #(
    parameter int N = 8
) ();
    localparam int ID_W = $clog2(N);

    logic            inta_i;
    logic            int_o;
    logic            vec_vld_o;
    logic [ID_W-1:0] vec_o;

    modport master (
        output inta_i,
        input  int_o, vec_o, vec_vld_o
    );

    modport slave (
        input  inta_i,
        output int_o, vec_o, vec_vld_o
    );
endinterface

// File: rtl/pic_prio_enc.sv
// Rotating priority encoder: returns the highest-priority set bit,
// where priority starts at (lowest+1) mod N and decreases cyclically.
module pic_prio_enc
    import pic_pkg::*;
#(
    parameter  int N    = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    vec_i,
    input  logic [ID_W-1:0] lowest_i,
    output logic            found_o,
    output logic [ID_W-1:0] level_o
);

    logic [63:0]     rot;
    logic [ID_W-1:0] off;

    always_comb begin
        rot     = rotate_prio(64'(vec_i), 32'(lowest_i), N);
        off     = '0;
        found_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off     = ID_W'(i);
                found_o = 1'b1;
            end
        end
        level_o = off + lowest_i + ID_W'(1);
    end

endmodule

// File: rtl/pic_isr_ctrl.sv
// In-service register and priority controller: nested/rotating priority,
// two-pulse INTA handshake, EOI/AEOI retirement.
module pic_isr_ctrl
    import pic_pkg::*;
#(
    parameter  int N    = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irr_i,
    input  logic [N-1:0]    imr_i,
    input  logic            aeoi_i,
    input  logic            eoi_i,
    input  logic [1:0]      eoi_cmd_i,
    input  logic            setpri_i,
    input  logic [ID_W-1:0] level_i,
    output logic [N-1:0]    irr_clr_o,
    output logic [N-1:0]    isr_o,
    pic_isr_ctrl_if.slave   cpu
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] lowest_q, lowest_d;
    logic [ID_W-1:0] vec_q, vec_d;
    logic [N-1:0]    isr_q, isr_d;
    logic [N-1:0]    clr_q, clr_d;
    logic            int_q, int_d;
    logic            vld_q, vld_d;
    logic            spur_q, spur_d;

    logic            c_found, s_found, qual;
    logic [ID_W-1:0] c_lvl, s_lvl, c_rank, s_rank;
    logic [N-1:0]    set_m, clr_m;

    pic_prio_enc #(.N(N)) u_req (
        .vec_i    (irr_i & ~imr_i),
        .lowest_i (lowest_q),
        .found_o  (c_found),
        .level_o  (c_lvl)
    );

    pic_prio_enc #(.N(N)) u_isr (
        .vec_i    (isr_q),
        .lowest_i (lowest_q),
        .found_o  (s_found),
        .level_o  (s_lvl)
    );

    // Rank 0 is the highest priority; wraps naturally at ID_W bits.
    assign c_rank = c_lvl - lowest_q - ID_W'(1);
    assign s_rank = s_lvl - lowest_q - ID_W'(1);
    assign qual   = c_found && (!s_found || (c_rank < s_rank));

    always_comb begin
        state_d  = state_q;
        lowest_d = lowest_q;
        vec_d    = vec_q;
        spur_d   = spur_q;
        clr_d    = '0;
        set_m    = '0;
        clr_m    = '0;

        unique case (state_q)
            IDLE: if (qual) state_d = PEND;
            PEND: begin
                if (cpu.inta_i) begin
                    state_d = ACK;
                    spur_d  = !qual;
                    if (qual) begin
                        vec_d = c_lvl;
                        set_m = N'(1) << c_lvl;
                        clr_d = N'(1) << c_lvl;
                    end else begin
                        vec_d = ID_W'(N - 1);
                    end
                end
            end
            ACK: begin
                if (cpu.inta_i) begin
                    state_d = IDLE;
                    if (aeoi_i && !spur_q) clr_m = N'(1) << vec_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (eoi_i) begin
            unique case (eoi_cmd_i)
                EOI_NS, EOI_RNS: begin
                    if (s_found) begin
                        clr_m = clr_m | (N'(1) << s_lvl);
                        if (eoi_cmd_i == EOI_RNS) lowest_d = s_lvl;
                    end
                end
                EOI_SP, EOI_RSP: begin
                    clr_m = clr_m | (N'(1) << level_i);
                    if (eoi_cmd_i == EOI_RSP) lowest_d = level_i;
                end
                default: ;
            endcase
        end

        if (setpri_i) lowest_d = level_i;

        // A set from the first INTA overrides any same-cycle clear.
        isr_d = (isr_q & ~clr_m) | set_m;
        int_d = (state_d == PEND);
        vld_d = (state_d == ACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lowest_q <= ID_W'(N - 1);
            vec_q    <= '0;
            isr_q    <= '0;
            clr_q    <= '0;
            int_q    <= 1'b0;
            vld_q    <= 1'b0;
            spur_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lowest_q <= lowest_d;
            vec_q    <= vec_d;
            isr_q    <= isr_d;
            clr_q    <= clr_d;
            int_q    <= int_d;
            vld_q    <= vld_d;
            spur_q   <= spur_d;
        end
    end

    assign cpu.int_o     = int_q;
    assign cpu.vec_o     = vec_q;
    assign cpu.vec_vld_o = vld_q;
    assign irr_clr_o     = clr_q;
    assign isr_o         = isr_q;

endmodule

// File: tb/tb_pic_isr_ctrl.sv
// Directed bench for pic_isr_ctrl at N=8, N=16 and N=2.
// Controls are shared; each build has its own request and level inputs.
module tb_pic_isr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aeoi = 1'b0;
    logic        inta = 1'b0;
    logic        eoi = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        setpri = 1'b0;

    logic [7:0]  irr8 = '0;
    logic [2:0]  lvl8 = 3'd7;
    logic [7:0]  clr8, isr8;
    logic [15:0] irr16 = '0;
    logic [3:0]  lvl16 = 4'd15;
    logic [15:0] clr16, isr16;
    logic [1:0]  irr2 = '0;
    logic [0:0]  lvl2 = 1'b1;
    logic [1:0]  clr2, isr2;

    int total = 0;
    int bad = 0;

    pic_isr_ctrl_if #(.N(8))  b8 ();
    pic_isr_ctrl_if #(.N(16)) b16 ();
    pic_isr_ctrl_if #(.N(2))  b2 ();

    assign b8.inta_i  = inta;
    assign b16.inta_i = inta;
    assign b2.inta_i  = inta;

    pic_isr_ctrl #(.N(8)) u8 (
        .clk(clk), .rst(rst), .irr_i(irr8), .imr_i(8'h00),
        .aeoi_i(aeoi), .eoi_i(eoi), .eoi_cmd_i(cmd),
        .setpri_i(setpri), .level_i(lvl8),
        .irr_clr_o(clr8), .isr_o(isr8), .cpu(b8.slave)
    );

    pic_isr_ctrl #(.N(16)) u16 (
        .clk(clk), .rst(rst), .irr_i(irr16), .imr_i(16'h0000),
        .aeoi_i(aeoi), .eoi_i(eoi), .eoi_cmd_i(cmd),
        .setpri_i(setpri), .level_i(lvl16),
        .irr_clr_o(clr16), .isr_o(isr16), .cpu(b16.slave)
    );

    pic_isr_ctrl #(.N(2)) u2 (
        .clk(clk), .rst(rst), .irr_i(irr2), .imr_i(2'b00),
        .aeoi_i(aeoi), .eoi_i(eoi), .eoi_cmd_i(cmd),
        .setpri_i(setpri), .level_i(lvl2),
        .irr_clr_o(clr2), .isr_o(isr2), .cpu(b2.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_int", 64'(b8.int_o), 64'd0);
        chk("rst_clr", 64'(clr8), 64'd0);
        chk("rst_vec", 64'(b8.vec_o), 64'd0);
        chk("rst_vld", 64'(b8.vec_vld_o), 64'd0);
        chk("rst_isr", 64'(isr8), 64'd0);
        #1 rst = 1'b0;

        // basic handshake: level 3 beats level 5
        irr8 = 8'h28;
        tick();
        chk("req_int", 64'(b8.int_o), 64'd1);
        ack();
        irr8 = 8'h20;
        chk("a1_vec", 64'(b8.vec_o), 64'd3);
        chk("a1_clr", 64'(clr8), 64'h08);
        chk("a1_isr", 64'(isr8), 64'h08);
        chk("a1_vld", 64'(b8.vec_vld_o), 64'd1);
        chk("a1_int", 64'(b8.int_o), 64'd0);
        tick();
        chk("clr_pulse", 64'(clr8), 64'h00);
        chk("ack_hold", 64'(b8.vec_vld_o), 64'd1);
        ack();
        chk("a2_vld", 64'(b8.vec_vld_o), 64'd0);
        chk("a2_isr", 64'(isr8), 64'h08);

        // nesting
        irr8 = 8'h10;
        tick();
        tick();
        chk("nest_low", 64'(b8.int_o), 64'd0);
        irr8 = 8'h02;
        tick();
        chk("nest_int", 64'(b8.int_o), 64'd1);
        ack();
        irr8 = 8'h00;
        chk("nest_vec", 64'(b8.vec_o), 64'd1);
        chk("nest_isr", 64'(isr8), 64'h0A);
        ack();
        eoi = 1'b1; cmd = 2'b00;
        tick();
        eoi = 1'b0;
        chk("eoi_ns", 64'(isr8), 64'h08);

        // rotate specific EOI at level 3
        eoi = 1'b1; cmd = 2'b11; lvl8 = 3'd3;
        tick();
        eoi = 1'b0;
        chk("eoi_rsp", 64'(isr8), 64'h00);
        irr8 = 8'h11;
        tick();
        chk("rot_int", 64'(b8.int_o), 64'd1);
        ack();
        irr8 = 8'h01;
        chk("rot_vec", 64'(b8.vec_o), 64'd4);
        chk("rot_isr", 64'(isr8), 64'h10);
        ack();
        tick();
        chk("rot_nest", 64'(b8.int_o), 64'd0);
        eoi = 1'b1; cmd = 2'b00;
        tick();
        eoi = 1'b0;
        chk("rot_eoi", 64'(isr8), 64'h00);

        // spurious: request withdrawn while pending
        tick();
        chk("sp_int", 64'(b8.int_o), 64'd1);
        irr8 = 8'h00;
        tick();
        chk("sp_hold", 64'(b8.int_o), 64'd1);
        ack();
        chk("sp_vec", 64'(b8.vec_o), 64'd7);
        chk("sp_isr", 64'(isr8), 64'h00);
        chk("sp_clr", 64'(clr8), 64'h00);
        chk("sp_vld", 64'(b8.vec_vld_o), 64'd1);
        ack();
        setpri = 1'b1; lvl8 = 3'd7;
        tick();
        setpri = 1'b0;

        // AEOI with a same-cycle specific EOI on the acknowledged bit
        aeoi = 1'b1;
        irr8 = 8'h04;
        tick();
        eoi = 1'b1; cmd = 2'b01; lvl8 = 3'd2;
        ack();
        eoi = 1'b0; lvl8 = 3'd7;
        irr8 = 8'h00;
        chk("ae_vec", 64'(b8.vec_o), 64'd2);
        chk("ae_setwin", 64'(isr8), 64'h04);
        ack();
        chk("ae_isr", 64'(isr8), 64'h00);
        chk("ae_vld", 64'(b8.vec_vld_o), 64'd0);
        aeoi = 1'b0;

        // asynchronous reset while in ACK
        irr8 = 8'h40;
        tick();
        ack();
        irr8 = 8'h00;
        chk("pre_isr", 64'(isr8), 64'h40);
        #2 rst = 1'b1;
        #1;
        chk("ar_int", 64'(b8.int_o), 64'd0);
        chk("ar_vld", 64'(b8.vec_vld_o), 64'd0);
        chk("ar_vec", 64'(b8.vec_o), 64'd0);
        chk("ar_isr", 64'(isr8), 64'h00);
        chk("ar_clr", 64'(clr8), 64'h00);
        #1 rst = 1'b0;
        tick();
        chk("ar_idle", 64'(b8.int_o), 64'd0);

        // N=16 and N=2: lowest=0 makes level 1 the top
        setpri = 1'b1; lvl16 = 4'd0; lvl2 = 1'b0;
        tick();
        setpri = 1'b0;
        irr16 = 16'h0003; irr2 = 2'b11;
        tick();
        chk("n16_int", 64'(b16.int_o), 64'd1);
        chk("n2_int", 64'(b2.int_o), 64'd1);
        ack();
        irr16 = 16'h0000; irr2 = 2'b00;
        chk("n16_vec_r", 64'(b16.vec_o), 64'd1);
        chk("n2_vec_r", 64'(b2.vec_o), 64'd1);
        chk("n16_isr", 64'(isr16), 64'h0002);
        chk("n2_clr", 64'(clr2), 64'h2);
        ack();
        eoi = 1'b1; cmd = 2'b00;
        tick();
        eoi = 1'b0;
        chk("n16_eoi", 64'(isr16), 64'h0000);
        setpri = 1'b1; lvl16 = 4'd15; lvl2 = 1'b1;
        tick();
        setpri = 1'b0;
        irr16 = 16'h0003; irr2 = 2'b11;
        tick();
        ack();
        irr16 = 16'h0000; irr2 = 2'b00;
        chk("n16_vec_d", 64'(b16.vec_o), 64'd0);
        chk("n2_vec_d", 64'(b2.vec_o), 64'd0);
        chk("n2_isr", 64'(isr2), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("n16_ar_isr", 64'(isr16), 64'h0000);
        chk("n16_ar_vld", 64'(b16.vec_vld_o), 64'd0);
        chk("n16_ar_clr", 64'(clr16), 64'h0000);
        chk("n2_ar_isr", 64'(isr2), 64'h0);
        chk("n2_ar_vld", 64'(b2.vec_vld_o), 64'd0);
        #1 rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pic_isr_ctrl.md
# pic_isr_ctrl

Parametrised in-service register and priority controller for the 8259-style interrupt controller, in the same position as the existing in-service register. It sits between the request/mask registers and the CPU acknowledge logic. It selects the winning request under fully-nested, rotating priority and runs the two-pulse INTA handshake. It holds in-service state in clocked flops and retires it on EOI commands or automatically (AEOI).

## Interface
- `N`, default 8: channel count; power of two, 2..64.
- `ID_W`, default `$clog2(N)`: level/vector index width; derived, not overridden.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `irr_i` in N: pending requests from the request register.
- `imr_i` in N: mask; 1 = channel masked.
- `aeoi_i` in 1: auto-EOI mode enable.
- `inta_i` in 1: acknowledge strobe; one cycle high per CPU INTA pulse.
- `eoi_i` in 1: one-cycle EOI command strobe.
- `eoi_cmd_i` in 2: 00 non-specific, 01 specific, 10 rotate non-specific, 11 rotate specific.
- `setpri_i` in 1: one-cycle strobe; sets the lowest-priority level to `level_i`.
- `level_i` in ID_W: level for specific EOI or set-priority.
- `int_o` out 1: interrupt request to CPU.
- `irr_clr_o` out N: one-hot, one-cycle pulse clearing the acknowledged IRR bit.
- `vec_o` out ID_W: acknowledged level.
- `vec_vld_o` out 1: high while in ACK state.
- `isr_o` out N: in-service register, for status readback.

## Operation
- Priority: `lowest` register, reset N-1. Highest priority is `(lowest+1) mod N`, decreasing cyclically. Wrap is natural ID_W overflow.
- Candidate: the highest-priority bit of `irr_i & ~imr_i`. It qualifies only if strictly higher in priority than the highest-priority set `isr` bit. If `isr` is empty, any candidate qualifies.
- Registered FSM states:
  - IDLE: if a candidate qualifies, go to PEND.
  - PEND: `int_o`=1. On `inta_i`:
    - If a qualifying candidate exists: latch its level into `vec_o`, set that `isr` bit, pulse `irr_clr_o` for that bit next cycle.
    - If none (request withdrawn): spurious. `vec_o`=N-1, `isr` unchanged, no `irr_clr_o`.
    - In either case, go to ACK.
  - PEND without `inta_i`: stay in PEND with `int_o` held, even if the request drops.
  - ACK: `vec_vld_o`=1. On `inta_i`, go to IDLE. If `aeoi_i` and the acknowledge was not spurious, clear the `vec_o` bit of `isr`.
- EOI, accepted in any state:
  - Non-specific: clears the highest-priority set `isr` bit. No-op if `isr` is empty.
  - Specific: clears `isr[level_i]`.
  - Rotate variants: also set `lowest` to the cleared level. Rotate non-specific with empty `isr` leaves `lowest` unchanged.
- `setpri_i`: `lowest` <= `level_i`. If it coincides with a rotate EOI, `setpri_i` wins.
- Same-cycle set (first INTA) and clear (EOI/AEOI) of the same `isr` bit: set wins. Clears of other bits apply normally.
- `inta_i` in IDLE is ignored.

## Timing
- Reset values: `int_o`=0, `irr_clr_o`=0, `vec_o`=0, `vec_vld_o`=0, `isr_o`=0, `lowest`=N-1, state IDLE.
- Reset mid-handshake returns to IDLE immediately. The ISR is cleared and no `irr_clr_o` pulse is issued.
- Latencies:
  - Request to `int_o`: 1 cycle (IDLE to PEND registered).
  - First `inta_i` to `irr_clr_o`, `vec_vld_o` and `isr_o` update: 1 cycle.
  - Second `inta_i` to `vec_vld_o` low and AEOI clear: 1 cycle.
  - `eoi_i` to `isr_o` and `lowest` update: 1 cycle.
- `int_o`, `vec_o`, `vec_vld_o`, `isr_o` and `irr_clr_o` are all registered. No combinational path exists from inputs to outputs.
- A back-to-back request may re-enter PEND the cycle after ACK exits.

## Structure
- Package `pic_pkg` holds:
  - state enum (IDLE/PEND/ACK);
  - EOI command localparams;
  - a rotate-by-`lowest` helper function.
- Sub-module `pic_prio_enc` (params N): rotating priority encoder.
  - Inputs: vector and `lowest`.
  - Outputs: `found` and `level`.
  - Instantiated twice, once on masked requests and once on `isr`.

## Test plan
- N=8, `irr`=0x28, `imr`=0, reset priority:
  - expect `int_o` one cycle later;
  - INTA1 gives `vec_o`=3, `irr_clr_o`=0x08, `isr_o`=0x08;
  - INTA2 drops `vec_vld_o`.
- Nesting: with `isr`=0x08, `irr`=0x10 does not raise `int_o`. `irr`=0x02 raises `int_o` and nests, giving `isr`=0x0A. Non-specific EOI clears bit 1, leaving 0x08.
- Rotation: rotate specific EOI with `level_i`=3 gives `lowest`=3. Then `irr`=0x11 acknowledges level 4 first.
- Spurious: `irr` drops while in PEND. INTA1 gives `vec_o`=7, `isr` unchanged, `irr_clr_o`=0.
- AEOI: with `aeoi_i`=1, after INTA2 `isr_o` returns to 0. Same-cycle EOI of the bit set by INTA1 leaves the bit set.
- N=16 and N=2 builds: set-priority `level_i`=N-1 restores default order. Reset asserted in ACK clears all outputs asynchronously.
